// File: rtl/exu_div_iter_pkg.sv
// Shared constants, state encoding and funct3 decode helpers for the
// iterative divider.
package exu_div_iter_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'd0,
        DIV_ST_CALC  = 2'd1,
        DIV_ST_FIXUP = 2'd2
    } div_state_e;

    // REM/REMU select the remainder, DIV/DIVU the quotient.
    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

    // DIVU/REMU use the operands as-is; anything else is treated as signed.
    function automatic logic op_is_unsigned(input logic [2:0] op);
        return (op == INST_DIVU) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/exu_div_iter_if.sv
// Start/result handshake between the mul/div control unit (master) and
// the iterative divider (slave).
interface exu_div_iter_if
    import exu_div_iter_pkg::*;
;
    logic                      start_i;
    logic [REG_DATA_WIDTH-1:0] dividend_i;
    logic [REG_DATA_WIDTH-1:0] divisor_i;
    logic [2:0]                op_i;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_i;
    logic                      ready_o;
    logic [REG_DATA_WIDTH-1:0] result_o;
    logic                      busy_o;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr_o;

    modport master (
        output start_i, dividend_i, divisor_i, op_i, reg_waddr_i,
        input  ready_o, result_o, busy_o, reg_waddr_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i, op_i, reg_waddr_i,
        output ready_o, result_o, busy_o, reg_waddr_o
    );
endinterface

// File: rtl/exu_div_iter_step.sv
// One radix-2 restoring division step, purely combinational. Kept apart
// from the FSM so a wider-radix step can replace it later.
module exu_div_iter_step
    import exu_div_iter_pkg::*;
(
    input  logic [REG_DATA_WIDTH:0]   rem_i,
    input  logic [REG_DATA_WIDTH-1:0] quo_i,
    input  logic [REG_DATA_WIDTH-1:0] div_i,
    output logic [REG_DATA_WIDTH:0]   rem_o,
    output logic [REG_DATA_WIDTH-1:0] quo_o
);

    logic [REG_DATA_WIDTH+1:0] rem_shift;
    logic [REG_DATA_WIDTH:0]   rem_diff;
    logic                      fits;

    // Shift the next dividend bit into R and subtract the divisor if it fits.
    always_comb begin
        rem_shift = {rem_i, quo_i[REG_DATA_WIDTH-1]};
        fits      = rem_shift >= {2'b00, div_i};
        rem_diff  = rem_shift[REG_DATA_WIDTH:0] - {1'b0, div_i};
        rem_o     = fits ? rem_diff : rem_shift[REG_DATA_WIDTH:0];
        quo_o     = {quo_i[REG_DATA_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/exu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Build option: DIV_ZERO_FASTPATH_EN sends a zero divisor straight from
// IDLE to FIXUP (one-edge latency) instead of running all 32 iterations.
module exu_div_iter
    import exu_div_iter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    exu_div_iter_if.slave div_if
);

    div_state_e                state_q;
    logic [4:0]                cnt_q;
    logic [REG_DATA_WIDTH:0]   rem_q;
    logic [REG_DATA_WIDTH-1:0] quo_q;
    logic [REG_DATA_WIDTH-1:0] abs_div_q;
    logic [REG_DATA_WIDTH-1:0] dividend_q;
    logic                      is_rem_q;
    logic                      neg_quo_q;
    logic                      neg_rem_q;
    logic                      div_zero_q;
    logic                      ready_q;
    logic                      busy_q;
    logic [REG_DATA_WIDTH-1:0] result_q;
    logic [REG_ADDR_WIDTH-1:0] waddr_q;

    logic                      in_signed;
    logic [REG_DATA_WIDTH-1:0] in_abs_dividend;
    logic [REG_DATA_WIDTH-1:0] in_abs_divisor;
    logic [REG_DATA_WIDTH:0]   step_rem;
    logic [REG_DATA_WIDTH-1:0] step_quo;
    logic [REG_DATA_WIDTH-1:0] fix_quo;
    logic [REG_DATA_WIDTH-1:0] fix_rem;
    logic [REG_DATA_WIDTH-1:0] fix_result;

    exu_div_iter_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (abs_div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Absolute values of the incoming operands, used only on accept.
    always_comb begin
        in_signed       = !op_is_unsigned(div_if.op_i);
        in_abs_dividend = div_if.dividend_i;
        in_abs_divisor  = div_if.divisor_i;
        if (in_signed && div_if.dividend_i[REG_DATA_WIDTH-1]) begin
            in_abs_dividend = -div_if.dividend_i;
        end
        if (in_signed && div_if.divisor_i[REG_DATA_WIDTH-1]) begin
            in_abs_divisor = -div_if.divisor_i;
        end
    end

    // Sign correction and result select; a zero divisor overrides the iteration result.
    always_comb begin
        fix_quo = neg_quo_q ? -quo_q : quo_q;
        fix_rem = neg_rem_q ? -rem_q[REG_DATA_WIDTH-1:0] : rem_q[REG_DATA_WIDTH-1:0];
        if (div_zero_q) begin
            fix_quo = '1;
            fix_rem = dividend_q;
        end
        fix_result = is_rem_q ? fix_rem : fix_quo;
    end

    // Control FSM: accept, 32 iterations, fixup, with abort on a dropped start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= DIV_ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            abs_div_q  <= '0;
            dividend_q <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ready_q    <= DIV_RESULT_NOT_READY;
            busy_q     <= 1'b0;
            result_q   <= '0;
            waddr_q    <= '0;
        end else begin
            ready_q <= DIV_RESULT_NOT_READY;
            case (state_q)
                DIV_ST_IDLE: begin
                    if (div_if.start_i == DIV_START && ready_q == DIV_RESULT_NOT_READY) begin
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        quo_q      <= in_abs_dividend;
                        abs_div_q  <= in_abs_divisor;
                        dividend_q <= div_if.dividend_i;
                        is_rem_q   <= op_is_rem(div_if.op_i);
                        neg_quo_q  <= in_signed &&
                                      (div_if.dividend_i[REG_DATA_WIDTH-1] ^ div_if.divisor_i[REG_DATA_WIDTH-1]);
                        neg_rem_q  <= in_signed && div_if.dividend_i[REG_DATA_WIDTH-1];
                        div_zero_q <= (div_if.divisor_i == '0);
                        waddr_q    <= div_if.reg_waddr_i;
                        result_q   <= '0;
                        busy_q     <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
                        state_q    <= (div_if.divisor_i == '0) ? DIV_ST_FIXUP : DIV_ST_CALC;
`else
                        state_q    <= DIV_ST_CALC;
`endif
                    end
                end
                DIV_ST_CALC: begin
                    if (div_if.start_i == DIV_STOP) begin
                        state_q  <= DIV_ST_IDLE;
                        busy_q   <= 1'b0;
                        result_q <= '0;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= step_quo;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= DIV_ST_FIXUP;
                        end
                    end
                end
                DIV_ST_FIXUP: begin
                    state_q <= DIV_ST_IDLE;
                    busy_q  <= 1'b0;
                    if (div_if.start_i == DIV_STOP) begin
                        result_q <= '0;
                    end else begin
                        result_q <= fix_result;
                        ready_q  <= DIV_RESULT_READY;
                    end
                end
                default: begin
                    state_q <= DIV_ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.ready_o     = ready_q;
    assign div_if.busy_o      = busy_q;
    assign div_if.result_o    = result_q;
    assign div_if.reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_exu_div_iter.sv
// Self-checking bench for exu_div_iter: directed corner cases, abort,
// reset and randomized operations against an arithmetic reference model.
module tb_exu_div_iter;
    import exu_div_iter_pkg::*;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif
    localparam int LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    exu_div_iter_if div_if ();

    exu_div_iter dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (div_if)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V division semantics straight from arithmetic rules.
    function automatic logic [31:0] refDiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic is_rem;
        is_rem = (op == INST_REM) || (op == INST_REMU);
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (op == INST_DIVU) return a / b;
        if (op == INST_REMU) return a % b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
        return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for ready (bounded).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic hold,
                                 output logic [31:0] res, output logic [4:0] rd_out,
                                 output int busy_cycles, output logic timed_out, output logic overlap);
        @(negedge clk);
        div_if.start_i     = 1'b1;
        div_if.op_i        = op;
        div_if.dividend_i  = a;
        div_if.divisor_i   = b;
        div_if.reg_waddr_i = rd;
        busy_cycles = 0;
        timed_out   = 1'b1;
        overlap     = 1'b0;
        res         = '0;
        rd_out      = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                div_if.dividend_i  = $urandom;
                div_if.divisor_i   = $urandom;
                div_if.reg_waddr_i = 5'($urandom);
            end
            if (div_if.ready_o && div_if.busy_o) overlap = 1'b1;
            if (div_if.ready_o) begin
                res       = div_if.result_o;
                rd_out    = div_if.reg_waddr_o;
                timed_out = 1'b0;
                break;
            end
            if (div_if.busy_o) busy_cycles++;
        end
        if (!hold) div_if.start_i = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rd_out;
        int          lat;
        logic        to;
        logic        ov;
        applyStimulus(op, a, b, rd, 1'b0, res, rd_out, lat, to, ov);
        checkOutput({tag, "_timeout"}, 32'(to), 32'd0);
        checkOutput({tag, "_result"}, res, exp);
        checkOutput({tag, "_waddr"}, 32'(rd_out), 32'(rd));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_overlap"}, 32'(ov), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 32'(div_if.ready_o), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  rd_out;
        int          lat;
        logic        to;
        logic        ov;
        logic        seen_ready;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rrd;

        div_if.start_i     = 1'b0;
        div_if.op_i        = INST_DIVU;
        div_if.dividend_i  = '0;
        div_if.divisor_i   = '0;
        div_if.reg_waddr_i = '0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(div_if.ready_o), 32'd0);
        checkOutput("rst_busy", 32'(div_if.busy_o), 32'd0);
        checkOutput("rst_result", div_if.result_o, 32'd0);
        checkOutput("rst_waddr", 32'(div_if.reg_waddr_o), 32'd0);
        rst = 1'b1;

        // Directed cases
        runOp("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, LAT);
        runOp("div_m7_2", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, LAT);
        runOp("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, LAT);
        runOp("remu_big_2", INST_REMU, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'd1, LAT);
        runOp("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, LAT);
        runOp("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, LAT);
        runOp("divu_5_0", INST_DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, ZLAT);
        runOp("remu_5_0", INST_REMU, 32'd5, 32'd0, 5'd8, 32'd5, ZLAT);
        runOp("div_m5_0", INST_DIV, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFF, ZLAT);
        runOp("rem_m5_0", INST_REM, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFB, ZLAT);

        // Start held through ready must not restart the divider
        applyStimulus(INST_DIVU, 32'd50, 32'd5, 5'd11, 1'b1, res, rd_out, lat, to, ov);
        checkOutput("hold_result", res, 32'd10);
        @(negedge clk);
        checkOutput("hold_busy", 32'(div_if.busy_o), 32'd0);
        checkOutput("hold_ready", 32'(div_if.ready_o), 32'd0);
        div_if.start_i = 1'b0;

        // Abort at iteration 10
        @(negedge clk);
        div_if.start_i    = 1'b1;
        div_if.op_i       = INST_DIVU;
        div_if.dividend_i = 32'd1000;
        div_if.divisor_i  = 32'd3;
        repeat (10) @(negedge clk);
        checkOutput("abort_busy_before", 32'(div_if.busy_o), 32'd1);
        div_if.start_i = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 32'(div_if.busy_o), 32'd0);
        checkOutput("abort_result", div_if.result_o, 32'd0);
        seen_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_if.ready_o) seen_ready = 1'b1;
        end
        checkOutput("abort_no_ready", 32'(seen_ready), 32'd0);
        runOp("divu_9_3", INST_DIVU, 32'd9, 32'd3, 5'd12, 32'd3, LAT);

        // Reset in the middle of CALC
        @(negedge clk);
        div_if.start_i     = 1'b1;
        div_if.op_i        = INST_DIV;
        div_if.dividend_i  = 32'd77;
        div_if.divisor_i   = 32'd4;
        div_if.reg_waddr_i = 5'd17;
        repeat (6) @(negedge clk);
        checkOutput("midrst_waddr_before", 32'(div_if.reg_waddr_o), 32'd17);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(div_if.ready_o), 32'd0);
        checkOutput("midrst_busy", 32'(div_if.busy_o), 32'd0);
        checkOutput("midrst_result", div_if.result_o, 32'd0);
        checkOutput("midrst_waddr", 32'(div_if.reg_waddr_o), 32'd0);
        div_if.start_i = 1'b0;
        rst = 1'b1;

        // Randomized operations against the reference model
        for (int n = 0; n < 24; n++) begin
            rop = INST_DIV + 3'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom);
            runOp($sformatf("rand%0d", n), rop, ra, rb, rrd, refDiv(rop, ra, rb), (rb == 32'd0) ? ZLAT : LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
